cdm_16_8000: RTL and testbench

//  16x16 unsigned carry-disregard approximate multiplier (CDM), registered output.
//  Low columns of the partial-product array are OR-compressed with no carries; upper

---
 rtl/cdm_16_8000.sv | 75 +++++++
 tb/tb_cdm_16_8000.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/cdm_16_8000.sv
// 16x16 unsigned carry-disregard approximate multiplier with a registered result.
// Optional exact-product override port enabled by defining CDM_EXACT_MODE_EN.
module cdm_16_8000 #(
  parameter int unsigned APPROX_COLS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] A,
  input  logic [15:0] B,
`ifdef CDM_EXACT_MODE_EN
  input  logic        exact,
`endif
  output logic        valid_out,
  output logic [31:0] R
);

  localparam logic [31:0] LOW_MASK = (APPROX_COLS == 0) ? 32'd0
                                   : ((32'd1 << APPROX_COLS) - 32'd1);
  localparam logic [31:0] HIGH_MASK = ~LOW_MASK;

  // Each row contributes its low-column bits only as an OR, and only its
  // high-column bits to the carry-propagating sum.
  function automatic logic [31:0] cdm_f(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] low_or;
    logic [31:0] high_sum;
    logic [31:0] row;
    low_or   = 32'd0;
    high_sum = 32'd0;
    for (int i = 0; i < 16; i++) begin
      if (a[i]) begin
        row = {16'd0, b} << i;
      end else begin
        row = 32'd0;
      end
      low_or   = low_or | (row & LOW_MASK);
      high_sum = high_sum + (row & HIGH_MASK);
    end
    return high_sum | low_or;
  endfunction

  logic [31:0] result_s;
  logic [31:0] r_r;
  logic        valid_r;

  // Select the product captured on the next accepted operand pair
  always_comb begin
    result_s = cdm_f(A, B);
`ifdef CDM_EXACT_MODE_EN
    if (exact) begin
      result_s = {16'd0, A} * {16'd0, B};
    end else begin
      result_s = cdm_f(A, B);
    end
`endif
  end

  // Result register: loads on valid_in, holds otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      r_r     <= 32'd0;
      valid_r <= 1'b0;
    end else if (valid_in) begin
      r_r     <= result_s;
      valid_r <= 1'b1;
    end else begin
      r_r     <= r_r;
      valid_r <= 1'b0;
    end
  end

  assign R         = r_r;
  assign valid_out = valid_r;

endmodule

// File: tb/tb_cdm_16_8000.sv
// Self-checking bench for cdm_16_8000: directed table, reset sequences and
// randomized back-to-back traffic against a column-counting reference model.
module tb_cdm_16_8000;

  localparam int AC = 16;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [15:0] a_s;
  logic [15:0] b_s;
  logic        exact_s;
  logic        valid_out;
  logic [31:0] r_s;

  int checks;
  int failures;

  cdm_16_8000 #(.APPROX_COLS(AC)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .A        (a_s),
    .B        (b_s),
`ifdef CDM_EXACT_MODE_EN
    .exact    (exact_s),
`endif
    .valid_out(valid_out),
    .R        (r_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vin;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] r;
    logic        v;
  } vec_t;

  // Count partial-product bits per weight column; low columns become a
  // presence flag, high columns are weighted and summed exactly.
  function automatic logic [31:0] ref_cdm(input logic [15:0] a, input logic [15:0] b);
    longint      h;
    logic [31:0] low;
    int          n;
    h   = 0;
    low = 32'd0;
    for (int c = 0; c < 31; c++) begin
      n = 0;
      for (int i = 0; i < 16; i++) begin
        if ((c - i >= 0) && (c - i < 16)) begin
          if (a[i] && b[c - i]) n = n + 1;
        end
      end
      if (c < AC) begin
        if (n != 0) low[c] = 1'b1;
      end else begin
        h = h + (longint'(n) << c);
      end
    end
    return low | h[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t        vecs[8];
  logic [31:0] exp_r;
  logic [31:0] prod;
  int          pa;
  int          pb;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    valid_in = 1'b1;
    a_s      = 16'hFFFF;
    b_s      = 16'hFFFF;
    exact_s  = 1'b0;
    #2;

    // Reset overrides valid_in for two cycles
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("reset_r", r_s, 32'h0);
      chk("reset_v", {31'd0, valid_out}, 32'h0);
    end
    rst = 1'b0;

    vecs[0] = '{1'b1, 16'h0003, 16'h0003, 32'h00000007, 1'b1};
    vecs[1] = '{1'b1, 16'hFFFF, 16'hFFFF, 32'hFFEFFFFF, 1'b1};
    vecs[2] = '{1'b1, 16'h0001, 16'hFFFF, 32'h0000FFFF, 1'b1};
    vecs[3] = '{1'b1, 16'h8000, 16'h8000, 32'h40000000, 1'b1};
    vecs[4] = '{1'b1, 16'hFFFF, 16'h0100, 32'h00FFFF00, 1'b1};
    vecs[5] = '{1'b0, 16'h5555, 16'h5555, 32'h00FFFF00, 1'b0};
    vecs[6] = '{1'b1, 16'h0000, 16'h1234, 32'h00000000, 1'b1};
    vecs[7] = '{1'b0, 16'h7777, 16'h1111, 32'h00000000, 1'b0};
    for (int k = 0; k < 8; k++) begin
      valid_in = vecs[k].vin;
      a_s      = vecs[k].a;
      b_s      = vecs[k].b;
      tick();
      chk($sformatf("vec%0d_r", k), r_s, vecs[k].r);
      chk($sformatf("vec%0d_v", k), {31'd0, valid_out}, {31'd0, vecs[k].v});
    end

    // Reset mid-stream discards the in-flight operands
    valid_in = 1'b1; a_s = 16'h0003; b_s = 16'h0005;
    tick();
    chk("pre_rst_r", r_s, 32'h0000000F);
    rst = 1'b1; a_s = 16'hFFFF; b_s = 16'hFFFF;
    tick();
    chk("mid_rst_r", r_s, 32'h0);
    chk("mid_rst_v", {31'd0, valid_out}, 32'h0);
    rst = 1'b0; valid_in = 1'b0;
    tick();
    chk("post_rst_idle_v", {31'd0, valid_out}, 32'h0);
    chk("post_rst_idle_r", r_s, 32'h0);
    valid_in = 1'b1; a_s = 16'h0002; b_s = 16'h0009;
    tick();
    chk("post_rst_first_r", r_s, 32'h00000012);
    chk("post_rst_first_v", {31'd0, valid_out}, 32'h1);

    // Randomized back-to-back traffic
    exp_r = r_s;
    for (int k = 0; k < 20000; k++) begin
      valid_in = ($urandom_range(3, 0) != 0);
      case ($urandom_range(3, 0))
        0:       a_s = 16'd1 << $urandom_range(15, 0);
        default: a_s = 16'($urandom);
      endcase
      b_s = 16'($urandom);
`ifdef CDM_EXACT_MODE_EN
      exact_s = $urandom_range(1, 0) == 1;
`endif
      prod = {16'd0, a_s} * {16'd0, b_s};
      pa   = $countones(a_s);
      pb   = $countones(b_s);
      if (valid_in) begin
        exp_r = exact_s ? prod : ref_cdm(a_s, b_s);
      end
      tick();
      chk("rand_r", r_s, exp_r);
      chk("rand_v", {31'd0, valid_out}, {31'd0, valid_in});
      if (valid_in && (pa <= 1 || pb <= 1)) chk("rand_pow2_exact", r_s, prod);
      if (valid_in && (r_s > prod)) chk("rand_le_exact", r_s, prod);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
